// File: rtl/replica_pkg.sv
// rtl/replica_pkg.sv - shared types and sizing helpers for the run scheduler
package replica_pkg;

  // Default number of base blocks swept per iteration.
  localparam int BASE_NUM_DEF = 4;

  // Width needed to index n base blocks; a single block still gets one bit.
  function automatic int base_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int base_log = base_width(BASE_NUM_DEF);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    OPT_ISSUE,
    OPT_WAIT,
    EX_ISSUE,
    EX_WAIT,
    FIN
  } run_state_t;

  typedef struct packed {
    logic timeout;
    logic cmd_overrun;
  } run_status_t;

endpackage

// File: rtl/run_scheduler_if.sv
// rtl/run_scheduler_if.sv - command, node-array and status signals of the run scheduler
interface run_scheduler_if #(
  parameter int BASE_LOG = 2,
  parameter int RUN_W    = 24
);

  logic                run_write;
  logic [RUN_W-1:0]    run_times;
  logic                abort;
  logic                opt_done;
  logic                exch_done;
  logic                running;
  logic                exp_init;
  logic                opt_run;
  logic [BASE_LOG-1:0] base_id;
  logic                exch_start;
  logic                exch_parity;
  logic [RUN_W-1:0]    iter_count;
  logic                run_done;
  logic [1:0]          status;

  // Bus/node side: issues commands and acknowledges, observes progress.
  modport master (
    output run_write, run_times, abort, opt_done, exch_done,
    input  running, exp_init, opt_run, base_id, exch_start, exch_parity,
           iter_count, run_done, status
  );

  // Scheduler side.
  modport slave (
    input  run_write, run_times, abort, opt_done, exch_done,
    output running, exp_init, opt_run, base_id, exch_start, exch_parity,
           iter_count, run_done, status
  );

endinterface

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating wait counter that flags a missing acknowledge
module run_watchdog #(
  parameter int WDOG_W = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_q;

  assign expired = &cnt_q;

  // Count while enabled, hold at all-ones, restart on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/run_scheduler.sv
// rtl/run_scheduler.sv - sequences optimisation sweeps and exchange phases of an annealing run
module run_scheduler
  import replica_pkg::*;
#(
  parameter int BASE_NUM = 4,
  parameter int RUN_W    = 24,
  parameter int WDOG_W   = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  run_scheduler_if.slave  bus
);

  localparam int BL = base_width(BASE_NUM);
  localparam logic [BL-1:0] BASE_LAST = BL'(BASE_NUM - 1);

  run_state_t       state_q, state_d;
  logic [BL-1:0]    base_q;
  logic [RUN_W-1:0] iter_q;
  logic [RUN_W-1:0] times_q;
  logic [RUN_W-1:0] iter_inc;
  logic             parity_q;
  logic             running_q;
  logic             abort_pend_q;
  run_status_t      status_q;
  logic             last_base;
  logic             exch_finish;
  logic             wd_en;
  logic             wd_expired;

  assign iter_inc    = iter_q + RUN_W'(1);
  assign last_base   = (base_q == BASE_LAST);
  // An abort arriving together with exch_done still ends the run after this exchange.
  assign exch_finish = (iter_inc == times_q) || abort_pend_q || bus.abort;
  assign wd_en       = (state_q == OPT_WAIT) || (state_q == EX_WAIT);

  run_watchdog #(.WDOG_W(WDOG_W)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!wd_en),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobe decode; a done always wins over a coincident watchdog expiry.
  always_comb begin
    state_d         = state_q;
    bus.exp_init    = 1'b0;
    bus.opt_run     = 1'b0;
    bus.exch_start  = 1'b0;
    bus.run_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run_write) begin
          state_d = (bus.run_times != '0) ? INIT : FIN;
        end
      end
      INIT: begin
        bus.exp_init = 1'b1;
        state_d      = OPT_ISSUE;
      end
      OPT_ISSUE: begin
        bus.opt_run = 1'b1;
        state_d     = OPT_WAIT;
      end
      OPT_WAIT: begin
        if (bus.opt_done) begin
          state_d = last_base ? EX_ISSUE : OPT_ISSUE;
        end else if (wd_expired) begin
          state_d = FIN;
        end
      end
      EX_ISSUE: begin
        bus.exch_start = 1'b1;
        state_d        = EX_WAIT;
      end
      EX_WAIT: begin
        if (bus.exch_done) begin
          state_d = exch_finish ? FIN : OPT_ISSUE;
        end else if (wd_expired) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bus.run_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping: latched length, sub-step index, iteration count, parity and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      times_q      <= '0;
      base_q       <= '0;
      iter_q       <= '0;
      parity_q     <= 1'b0;
      running_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      status_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run_write) begin
            times_q      <= bus.run_times;
            base_q       <= '0;
            iter_q       <= '0;
            parity_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            status_q     <= '0;
            running_q    <= (bus.run_times != '0);
          end
        end
        OPT_WAIT: begin
          if (bus.opt_done) begin
            base_q <= last_base ? '0 : base_q + BL'(1);
          end else if (wd_expired) begin
            status_q.timeout <= 1'b1;
          end
        end
        EX_WAIT: begin
          if (bus.exch_done) begin
            iter_q   <= iter_inc;
            parity_q <= ~parity_q;
          end else if (wd_expired) begin
            status_q.timeout <= 1'b1;
          end
        end
        FIN: begin
          running_q    <= 1'b0;
          abort_pend_q <= 1'b0;
        end
        default: ;
      endcase
      if (state_q != IDLE) begin
        if (bus.run_write) status_q.cmd_overrun <= 1'b1;
        if (bus.abort)     abort_pend_q <= 1'b1;
      end
    end
  end

  assign bus.running     = running_q;
  assign bus.base_id     = base_q;
  assign bus.exch_parity = parity_q;
  assign bus.iter_count  = iter_q;
  assign bus.status      = status_q;

endmodule

// File: tb/tb_run_scheduler.sv
// tb/tb_run_scheduler.sv - directed self-checking bench for run_scheduler
module tb_run_scheduler;

  localparam int BASE_NUM = 4;
  localparam int RUN_W    = 24;
  localparam int WDOG_W   = 10;
  localparam int BL       = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  run_scheduler_if #(.BASE_LOG(BL), .RUN_W(RUN_W)) bus ();

  run_scheduler #(.BASE_NUM(BASE_NUM), .RUN_W(RUN_W), .WDOG_W(WDOG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_opt, n_exch, n_done, n_init;
  int   opt_cd        = -1;
  int   exch_cd       = -1;
  int   withhold_base = -1;
  int   base_seq[$];
  int   par_seq[$];
  int   opt_cyc[$];
  int   done_cyc;
  logic running_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_opt = 0; n_exch = 0; n_done = 0; n_init = 0;
    base_seq.delete(); par_seq.delete(); opt_cyc.delete();
    done_cyc = 0; running_at_done = 1'b0;
  endtask

  // One clock: drop last cycle's pulses, play the node array, record DUT strobes.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    bus.run_write = 1'b0;
    bus.abort     = 1'b0;
    bus.opt_done  = 1'b0;
    bus.exch_done = 1'b0;
    if (opt_cd > 0) begin
      opt_cd--;
      if (opt_cd == 0) begin bus.opt_done = 1'b1; opt_cd = -1; end
    end
    if (exch_cd > 0) begin
      exch_cd--;
      if (exch_cd == 0) begin bus.exch_done = 1'b1; exch_cd = -1; end
    end
    if (bus.opt_run) begin
      n_opt++;
      base_seq.push_back(int'(bus.base_id));
      opt_cyc.push_back(cyc);
      if (int'(bus.base_id) != withhold_base) opt_cd = 2;
    end
    if (bus.exch_start) begin
      n_exch++;
      par_seq.push_back(int'(bus.exch_parity));
      exch_cd = 2;
    end
    if (bus.exp_init) n_init++;
    if (bus.run_done) begin
      n_done++;
      done_cyc = cyc;
      running_at_done = bus.running;
    end
  endtask

  task automatic start(input int times);
    tick();
    bus.run_times = RUN_W'(times);
    bus.run_write = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n0 = n_done;
    for (int i = 0; i < bound && n_done == n0; i++) tick();
    chk(tag, 32'(n_done - n0), 1);
  endtask

  task automatic wait_opt(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && n_opt < n; i++) tick();
    chk(tag, n_opt, n);
  endtask

  task automatic wait_exch(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && n_exch < n; i++) tick();
    chk(tag, n_exch, n);
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({bus.running, bus.exp_init, bus.opt_run, bus.exch_start,
                bus.exch_parity, bus.run_done, bus.base_id, bus.status});
  endfunction

  initial begin
    bus.run_write = 1'b0;
    bus.run_times = '0;
    bus.abort     = 1'b0;
    bus.opt_done  = 1'b0;
    bus.exch_done = 1'b0;
    clear_stats();

    // Reset values
    repeat (3) tick();
    chk("rst_ctl", ctl_vec(), 0);
    chk("rst_iter", 32'(bus.iter_count), 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ctl", ctl_vec(), 0);

    // Nominal run of three iterations
    clear_stats();
    start(3);
    chk("t3_exp_init", 32'(bus.exp_init), 1);
    chk("t3_running", 32'(bus.running), 1);
    tick();
    chk("t3_first_opt", 32'(bus.opt_run), 1);
    chk("t3_first_base", 32'(bus.base_id), 0);
    wait_done("t3_done_seen", 200);
    chk("t3_n_opt", n_opt, 12);
    if (base_seq.size() == 12)
      for (int i = 0; i < 12; i++) chk("t3_base_seq", base_seq[i], i % 4);
    chk("t3_opt_period", opt_cyc[1] - opt_cyc[0], 3);
    chk("t3_n_exch", n_exch, 3);
    if (par_seq.size() == 3)
      for (int i = 0; i < 3; i++) chk("t3_parity", par_seq[i], i % 2);
    chk("t3_n_done", n_done, 1);
    chk("t3_running_at_done", 32'(running_at_done), 1);
    chk("t3_iter", 32'(bus.iter_count), 3);
    chk("t3_status", 32'(bus.status), 0);
    tick();
    chk("t3_running_after", 32'(bus.running), 0);
    chk("t3_done_pulse_len", 32'(bus.run_done), 0);
    chk("t3_n_init", n_init, 1);

    // Zero-length run
    clear_stats();
    start(0);
    chk("t0_run_done", 32'(bus.run_done), 1);
    chk("t0_running", 32'(bus.running), 0);
    repeat (3) tick();
    chk("t0_n_init", n_init, 0);
    chk("t0_n_opt", n_opt, 0);
    chk("t0_n_exch", n_exch, 0);
    chk("t0_iter", 32'(bus.iter_count), 0);
    chk("t0_n_done", n_done, 1);

    // Abort during the second OPT_WAIT of a ten-iteration run
    clear_stats();
    start(10);
    wait_opt("ab_reach_opt2", 2, 100);
    tick();
    bus.abort = 1'b1;
    tick();
    wait_done("ab_done_seen", 300);
    chk("ab_n_opt", n_opt, 4);
    chk("ab_n_exch", n_exch, 1);
    chk("ab_iter", 32'(bus.iter_count), 1);
    chk("ab_n_done", n_done, 1);

    // Watchdog: opt_done never returned for base block 2
    clear_stats();
    withhold_base = 2;
    start(3);
    wait_done("wd_done_seen", 1300);
    withhold_base = -1;
    chk("wd_status", 32'(bus.status), 2);
    chk("wd_iter", 32'(bus.iter_count), 0);
    chk("wd_n_opt", n_opt, 3);
    chk("wd_n_exch", n_exch, 0);
    chk("wd_latency", done_cyc - opt_cyc[2], 1025);

    // run_write while a run is in progress
    clear_stats();
    start(2);
    wait_opt("ov_reach_opt1", 1, 50);
    bus.run_times = RUN_W'(7);
    bus.run_write = 1'b1;
    tick();
    chk("ov_status_set", 32'(bus.status), 1);
    wait_done("ov_done_seen", 200);
    chk("ov_status_hold", 32'(bus.status), 1);
    chk("ov_iter", 32'(bus.iter_count), 2);
    chk("ov_n_opt", n_opt, 8);
    chk("ov_n_exch", n_exch, 2);
    clear_stats();
    start(1);
    chk("ov_status_clear", 32'(bus.status), 0);
    wait_done("ov2_done_seen", 100);
    chk("ov2_iter", 32'(bus.iter_count), 1);

    // Reset asserted while waiting for the second exchange
    clear_stats();
    start(5);
    wait_exch("rs_reach_exch2", 2, 200);
    tick();
    chk("rs_pre_iter", 32'(bus.iter_count), 1);
    chk("rs_pre_parity", 32'(bus.exch_parity), 1);
    reset_n = 1'b0;
    #1;
    chk("rs_ctl_async", ctl_vec(), 0);
    chk("rs_iter_async", 32'(bus.iter_count), 0);
    opt_cd  = -1;
    exch_cd = -1;
    repeat (3) tick();
    chk("rs_no_done", n_done, 0);
    reset_n = 1'b1;
    clear_stats();
    start(1);
    wait_done("rs_fresh_done", 100);
    chk("rs_fresh_n_exch", n_exch, 1);
    if (par_seq.size() == 1) chk("rs_fresh_parity", par_seq[0], 0);
    chk("rs_fresh_iter", 32'(bus.iter_count), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
